pe_mac_multimode: RTL and testbench

- Next-generation systolic processing element: a signed multiply-accumulate with LANES parallel products reduced per cycle.
- Two-stage pipeline: multiply, then accumulate.
- Run-time selectable dataflow: input-stationary (IS) or output-stationary (OS), with optional saturating accumulation and a sticky overflow flag.
- Tiles into the systolic array; input/weight/psum are forwarded to neighbours exactly as the existing PE does.

---
 rtl/pe_mac_multimode_if.sv | 32 +++
 rtl/pe_mac_multimode.sv | 131 +++++++++++++
 tb/tb_pe_mac_multimode.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_multimode_if.sv
// Control and data bundle between one pe_mac_multimode tile and its driver.
// The master modport drives the tile; the slave modport is the tile itself.
interface pe_mac_multimode_if #(
    parameter int INPUT_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int PSUM_WIDTH   = 32,
    parameter int LANES        = 1
);
    logic                          mode;
    logic                          load_en;
    logic                          process_en;
    logic                          drain_en;
    logic [LANES*INPUT_WIDTH-1:0]  input_in;
    logic [LANES*WEIGHT_WIDTH-1:0] weight_in;
    logic [PSUM_WIDTH-1:0]         psum_in;
    logic [LANES*INPUT_WIDTH-1:0]  input_out;
    logic [LANES*WEIGHT_WIDTH-1:0] weight_out;
    logic [PSUM_WIDTH-1:0]         psum_out;
    logic                          psum_valid;
    logic                          busy;
    logic                          ovf;

    modport master (
        output mode, load_en, process_en, drain_en, input_in, weight_in, psum_in,
        input  input_out, weight_out, psum_out, psum_valid, busy, ovf
    );

    modport slave (
        input  mode, load_en, process_en, drain_en, input_in, weight_in, psum_in,
        output input_out, weight_out, psum_out, psum_valid, busy, ovf
    );
endinterface

// File: rtl/pe_mac_multimode.sv
// Systolic PE: LANES signed products summed per beat, then accumulated either
// into the forwarded partial sum (input-stationary) or a local acc (output-stationary).
module pe_mac_multimode #(
    parameter int INPUT_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int PSUM_WIDTH   = 32,
    parameter int LANES        = 1,
    parameter int SATURATE     = 1
) (
    input logic               clk,
    input logic               rst_n,
    pe_mac_multimode_if.slave bus
);
    localparam int MUL_W  = INPUT_WIDTH + WEIGHT_WIDTH;
    localparam int PROD_W = MUL_W + $clog2(LANES);
    // One guard bit above whichever operand is wider, so the stage-2 sum never wraps.
    localparam int SUM_W  = ((PROD_W > PSUM_WIDTH) ? PROD_W : PSUM_WIDTH) + 1;
    localparam logic signed [SUM_W-1:0] PMAX =
        {{(SUM_W-PSUM_WIDTH+1){1'b0}}, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] PMIN =
        {{(SUM_W-PSUM_WIDTH+1){1'b1}}, {(PSUM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                        state_q, state_d;
    logic                          mode_reg;
    logic [LANES*INPUT_WIDTH-1:0]  input_reg;
    logic [LANES*WEIGHT_WIDTH-1:0] weight_reg;
    logic signed [PROD_W-1:0]      prod_reg, prod_sum;
    logic signed [PSUM_WIDTH-1:0]  psum_d, acc, psum_out_q, s2_result;
    logic signed [SUM_W-1:0]       sum_wide;
    logic                          v1, psum_valid_q, ovf_q, s2_ovf;
    logic                          eff_mode, drain_go;

    // In IDLE the live mode pin governs the beat that leaves IDLE; afterwards it is frozen.
    assign eff_mode = (state_q == IDLE) ? bus.mode : mode_reg;
    assign drain_go = (state_q == IDLE) && bus.mode && bus.drain_en;

    // NOTE: every signal written in an always_comb gets a default at the top so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.process_en)  state_d = RUN;
            RUN:     if (!bus.process_en) state_d = FLUSH;
            FLUSH:   state_d = bus.process_en ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            logic signed [INPUT_WIDTH-1:0]  a_l;
            logic signed [WEIGHT_WIDTH-1:0] w_l;
            a_l = eff_mode ? bus.input_in[l*INPUT_WIDTH +: INPUT_WIDTH]
                           : input_reg[l*INPUT_WIDTH +: INPUT_WIDTH];
            w_l = bus.weight_in[l*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            prod_sum = prod_sum + PROD_W'(MUL_W'(a_l) * MUL_W'(w_l));
        end
    end

    always_comb begin
        sum_wide  = SUM_W'(mode_reg ? acc : psum_d) + SUM_W'(prod_reg);
        s2_ovf    = (sum_wide > PMAX) || (sum_wide < PMIN);
        s2_result = sum_wide[PSUM_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (sum_wide > PMAX)      s2_result = PMAX[PSUM_WIDTH-1:0];
            else if (sum_wide < PMIN) s2_result = PMIN[PSUM_WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: this datapath is flops only, so every register is cleared; an in-flight beat dies with v1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg     <= 1'b0;
            input_reg    <= '0;
            weight_reg   <= '0;
            prod_reg     <= '0;
            psum_d       <= '0;
            acc          <= '0;
            psum_out_q   <= '0;
            psum_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            v1           <= 1'b0;
        end else begin
            psum_valid_q <= 1'b0;
            v1           <= bus.process_en;
            if (state_q == IDLE) mode_reg <= bus.mode;

            if (bus.process_en) begin
                prod_reg   <= prod_sum;
                psum_d     <= bus.psum_in;
                weight_reg <= bus.weight_in;
            end

            // IS keeps the operand stationary until reloaded; OS streams it through for forwarding.
            if (eff_mode ? bus.process_en : bus.load_en) input_reg <= bus.input_in;

            if (v1) begin
                if (mode_reg) begin
                    acc <= s2_result;
                end else begin
                    psum_out_q   <= s2_result;
                    psum_valid_q <= 1'b1;
                end
                if (s2_ovf) ovf_q <= 1'b1;
            end

            // v1 is never set in IDLE, so a drain cannot collide with a stage-2 update.
            if (drain_go) begin
                psum_out_q   <= acc;
                acc          <= '0;
                ovf_q        <= 1'b0;
                psum_valid_q <= 1'b1;
            end
        end
    end

    assign bus.input_out  = input_reg;
    assign bus.weight_out = weight_reg;
    assign bus.psum_out   = psum_out_q;
    assign bus.psum_valid = psum_valid_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_pe_mac_multimode.sv
// Directed bench for pe_mac_multimode: IS/OS dataflow, lanes, saturation vs wrap,
// FSM/busy behaviour and asynchronous reset in mid-pipeline.
module tb_pe_mac_multimode;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pe_mac_multimode_if #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(32), .LANES(1)) b1 ();
    pe_mac_multimode_if #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(32), .LANES(4)) b4 ();
    pe_mac_multimode_if #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(16), .LANES(1)) bs ();
    pe_mac_multimode_if #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(16), .LANES(1)) bw ();

    pe_mac_multimode #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(32), .LANES(1), .SATURATE(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    pe_mac_multimode #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(32), .LANES(4), .SATURATE(1))
        u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    pe_mac_multimode #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(16), .LANES(1), .SATURATE(1))
        us (.clk(clk), .rst_n(rst_n), .bus(bs));
    pe_mac_multimode #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(16), .LANES(1), .SATURATE(0))
        uw (.clk(clk), .rst_n(rst_n), .bus(bw));

    // The wrapping tile sees exactly the stimulus of the saturating one.
    assign bw.mode       = bs.mode;
    assign bw.load_en    = bs.load_en;
    assign bw.process_en = bs.process_en;
    assign bw.drain_en   = bs.drain_en;
    assign bw.input_in   = bs.input_in;
    assign bw.weight_in  = bs.weight_in;
    assign bw.psum_in    = bs.psum_in;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] w;
        logic signed [31:0] p;
        logic signed [31:0] exp_psum;
        logic               exp_ovf;
    } is_vec_t;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] w;
        logic signed [15:0] p;
        logic signed [15:0] exp_sat;
        logic signed [15:0] exp_wrap;
        logic               exp_ovf;
    } sat_vec_t;

    is_vec_t  is_tab[6];
    sat_vec_t sat_tab[3];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        is_tab[0] = '{16'sd3,      -16'sd4,     32'sd10,         -32'sd2,          1'b0};
        is_tab[1] = '{-16'sd7,     -16'sd8,     32'sd0,          32'sd56,          1'b0};
        is_tab[2] = '{16'sd100,    16'sd200,    -32'sd30000,     -32'sd10000,      1'b0};
        is_tab[3] = '{16'sd32767,  16'sd32767,  32'sd5,          32'sd1073676294,  1'b0};
        is_tab[4] = '{16'sh8000,   16'sh8000,   32'sd2147483647, 32'sd2147483647,  1'b1};
        is_tab[5] = '{16'sd1,      16'sd1,      -32'sd5,         -32'sd4,          1'b1};

        sat_tab[0] = '{16'sd2,  16'sd3, 16'sd100,   16'sd106,   16'sd106,   1'b0};
        sat_tab[1] = '{16'sd1,  16'sd1, 16'sd32767, 16'sd32767, 16'sh8000,  1'b1};
        sat_tab[2] = '{-16'sd1, 16'sd1, 16'sh8000,  16'sh8000,  16'sd32767, 1'b1};

        {b1.mode, b1.load_en, b1.process_en, b1.drain_en} = '0;
        {b4.mode, b4.load_en, b4.process_en, b4.drain_en} = '0;
        {bs.mode, bs.load_en, bs.process_en, bs.drain_en} = '0;
        b1.input_in = '0; b1.weight_in = '0; b1.psum_in = '0;
        b4.input_in = '0; b4.weight_in = '0; b4.psum_in = '0;
        bs.input_in = '0; bs.weight_in = '0; bs.psum_in = '0;

        // Reset state
        tick(); tick();
        check("rst_psum_out", $signed(b1.psum_out), 0);
        check("rst_valid", b1.psum_valid, 0);
        check("rst_busy", b1.busy, 0);
        check("rst_ovf", b1.ovf, 0);
        check("rst_l4_psum", $signed(b4.psum_out), 0);
        check("rst_s16_psum", $signed(bs.psum_out), 0);
        rst_n = 1'b1;

        // IS single lane, table-driven: load, beat, result at beat+2
        for (int i = 0; i < 6; i++) begin
            tick(); b1.mode = 1'b0; b1.load_en = 1'b1; b1.input_in = is_tab[i].a;
            tick(); b1.load_en = 1'b0; b1.process_en = 1'b1;
                    b1.weight_in = is_tab[i].w; b1.psum_in = is_tab[i].p;
            tick(); b1.process_en = 1'b0;
            check($sformatf("is%0d_wout", i), $signed(b1.weight_out), is_tab[i].w);
            check($sformatf("is%0d_early_valid", i), b1.psum_valid, 0);
            tick();
            check($sformatf("is%0d_psum", i), $signed(b1.psum_out), is_tab[i].exp_psum);
            check($sformatf("is%0d_valid", i), b1.psum_valid, 1);
            check($sformatf("is%0d_ovf", i), b1.ovf, is_tab[i].exp_ovf);
            tick();
            check($sformatf("is%0d_valid_drop", i), b1.psum_valid, 0);
        end

        // IS four lanes, load_en coinciding with a beat
        tick(); b4.load_en = 1'b1; b4.input_in = pack4(1, 2, 3, 4);
        tick(); b4.input_in = pack4(9, 9, 9, 9); b4.process_en = 1'b1;
                b4.weight_in = pack4(5, 6, 7, 8); b4.psum_in = '0;
        tick(); b4.load_en = 1'b0;
        check("l4_input_out", $signed(b4.input_out), $signed(pack4(9, 9, 9, 9)));
        tick(); b4.process_en = 1'b0; b4.load_en = 1'b1; b4.input_in = pack4(-1, 2, -3, 4);
        check("l4_old_input", $signed(b4.psum_out), 70);
        check("l4_old_valid", b4.psum_valid, 1);
        tick(); b4.load_en = 1'b0; b4.process_en = 1'b1;
                b4.weight_in = pack4(5, -6, 7, 8); b4.psum_in = 32'sd100;
        check("l4_new_input", $signed(b4.psum_out), 234);
        tick(); b4.process_en = 1'b0;
        check("l4_gap_valid", b4.psum_valid, 0);
        tick();
        check("l4_signed_lanes", $signed(b4.psum_out), 94);
        tick(); tick();

        // OS accumulate with a drain attempted during RUN
        tick(); b1.mode = 1'b1; b1.process_en = 1'b1; b1.input_in = 16'sd2; b1.weight_in = 16'sd3;
        tick(); b1.input_in = 16'sd4; b1.weight_in = 16'sd5; b1.drain_en = 1'b1;
        check("os_input_out", $signed(b1.input_out), 2);
        check("os_busy", b1.busy, 1);
        tick(); b1.drain_en = 1'b0; b1.input_in = -16'sd1; b1.weight_in = 16'sd6;
        check("os_run_drain_ignored", $signed(b1.psum_out), -4);
        check("os_run_valid0", b1.psum_valid, 0);
        tick(); b1.process_en = 1'b0;
        check("os_run_valid1", b1.psum_valid, 0);
        tick();
        check("os_flush_valid", b1.psum_valid, 0);
        check("os_ovf_sticky", b1.ovf, 1);
        tick(); b1.drain_en = 1'b1;
        check("os_idle_busy", b1.busy, 0);
        tick(); b1.drain_en = 1'b0;
        check("os_drain_psum", $signed(b1.psum_out), 20);
        check("os_drain_valid", b1.psum_valid, 1);
        check("os_drain_ovf_clr", b1.ovf, 0);
        tick(); b1.drain_en = 1'b1;
        check("os_drain_pulse", b1.psum_valid, 0);
        tick(); b1.drain_en = 1'b0;
        check("os_acc_cleared", $signed(b1.psum_out), 0);
        check("os_acc_cleared_valid", b1.psum_valid, 1);
        tick(); b1.mode = 1'b0; b1.drain_en = 1'b1;
        tick(); b1.drain_en = 1'b0;
        check("is_drain_ignored", b1.psum_valid, 0);

        // Saturating vs wrapping 16-bit accumulators, driven identically
        for (int i = 0; i < 3; i++) begin
            tick(); bs.load_en = 1'b1; bs.input_in = sat_tab[i].a;
            tick(); bs.load_en = 1'b0; bs.process_en = 1'b1;
                    bs.weight_in = sat_tab[i].w; bs.psum_in = sat_tab[i].p;
            tick(); bs.process_en = 1'b0;
            tick();
            check($sformatf("sat%0d_psum", i), $signed(bs.psum_out), sat_tab[i].exp_sat);
            check($sformatf("wrap%0d_psum", i), $signed(bw.psum_out), sat_tab[i].exp_wrap);
            check($sformatf("sat%0d_ovf", i), bs.ovf, sat_tab[i].exp_ovf);
            check($sformatf("wrap%0d_ovf", i), bw.ovf, sat_tab[i].exp_ovf);
            tick();
        end

        // Mode toggled mid-burst stays OS; busy spans two cycles past the last beat
        tick(); b1.mode = 1'b1; b1.process_en = 1'b1; b1.input_in = 16'sd1;
                b1.weight_in = 16'sd1; b1.psum_in = '0;
        tick(); b1.mode = 1'b0; b1.load_en = 1'b1; b1.psum_in = 32'sd1000;
        check("fsm_busy_first", b1.busy, 1);
        tick();
        check("fsm_mode_frozen0", b1.psum_valid, 0);
        tick(); b1.process_en = 1'b0; b1.load_en = 1'b0;
        check("fsm_mode_frozen1", b1.psum_valid, 0);
        check("fsm_busy_run", b1.busy, 1);
        tick();
        check("fsm_busy_last1", b1.busy, 1);
        check("fsm_mode_frozen2", b1.psum_valid, 0);
        tick(); b1.mode = 1'b1; b1.drain_en = 1'b1;
        check("fsm_busy_last2", b1.busy, 0);
        tick(); b1.drain_en = 1'b0;
        check("fsm_os_sum", $signed(b1.psum_out), 3);
        check("fsm_os_valid", b1.psum_valid, 1);

        // Asynchronous reset one cycle after a beat
        tick(); b1.mode = 1'b0; b1.load_en = 1'b1; b1.input_in = 16'sd5;
        tick(); b1.load_en = 1'b0; b1.process_en = 1'b1; b1.weight_in = 16'sd5; b1.psum_in = '0;
        tick(); b1.process_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_psum_out", $signed(b1.psum_out), 0);
        check("arst_weight_out", $signed(b1.weight_out), 0);
        check("arst_input_out", $signed(b1.input_out), 0);
        check("arst_busy", b1.busy, 0);
        check("arst_valid", b1.psum_valid, 0);
        check("arst_l4_psum", $signed(b4.psum_out), 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_valid%0d", i), b1.psum_valid, 0);
            check($sformatf("post_rst_psum%0d", i), $signed(b1.psum_out), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
